// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared access-type codes, FSM states and lane helpers for the
//               parametrised data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam logic [2:0] DM_WORD  = 3'b000;
    localparam logic [2:0] DM_HALF  = 3'b001;
    localparam logic [2:0] DM_HALFU = 3'b010;
    localparam logic [2:0] DM_BYTE  = 3'b011;
    localparam logic [2:0] DM_BYTEU = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } dm_state_e;

    function automatic logic [2:0] type_size(input logic [2:0] typ);
        case (typ)
            DM_WORD:           return 3'd4;
            DM_HALF, DM_HALFU: return 3'd2;
            DM_BYTE, DM_BYTEU: return 3'd1;
            default:           return 3'd0;
        endcase
    endfunction

    function automatic logic type_illegal(input logic [2:0] typ);
        return typ > DM_BYTEU;
    endfunction

    // Byte enables across two consecutive words; bits [7:4] address the next word.
    function automatic logic [7:0] lane_be(input logic [2:0] typ, input logic [1:0] off);
        logic [7:0] mask;
        case (typ)
            DM_WORD:           mask = 8'h0F;
            DM_HALF, DM_HALFU: mask = 8'h03;
            DM_BYTE, DM_BYTEU: mask = 8'h01;
            default:           mask = 8'h00;
        endcase
        return mask << off;
    endfunction

    function automatic logic [63:0] store_align(input logic [31:0] wdata, input logic [1:0] off);
        return {32'd0, wdata} << {off, 3'b000};
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] typ,
                                                input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (typ)
            DM_HALF:  return {{16{s[15]}}, s[15:0]};
            DM_HALFU: return {16'd0, s[15:0]};
            DM_BYTE:  return {{24{s[7]}}, s[7:0]};
            DM_BYTEU: return {24'd0, s[7:0]};
            default:  return s;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_ram.sv
`default_nettype none
// ============================================================================
// Module      : dm_ram
// Description : DEPTH x 32 single-port RAM, byte enables, synchronous read.
//               Unwritten bytes read as the INIT_SEQ image (byte i = i[7:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module dm_ram #(
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter int INIT_SEQ = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem       [DEPTH];
    logic [3:0]  written_q [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] w_rd_data;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Per-byte "written" flags select between stored data and the init image.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                written_q[i] <= 4'b0000;
            end
        end else if (en_i && we_i) begin
            written_q[addr_i] <= written_q[addr_i] | be_i;
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_lane
        localparam logic [1:0] C_LANE = 2'(b);
        logic [AW+1:0] w_byte_addr;
        logic [7:0]    w_init;
        assign w_byte_addr = {addr_i, C_LANE};
        assign w_init      = (INIT_SEQ != 0) ? 8'(w_byte_addr) : 8'h00;
        assign w_rd_data[8*b +: 8] = written_q[addr_i][b] ? mem[addr_i][8*b +: 8] : w_init;
    end

    always_ff @(posedge clk) begin
        if (en_i && !we_i) begin
            rdata_q <= w_rd_data;
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_param.sv
`default_nettype none
// ============================================================================
// Module      : dmem_param
// Description : Parametrised data memory with valid/ready request/response,
//               signed/unsigned sub-word loads and alignment/range errors.
//               Build option DM_MISALIGN_SPLIT_EN enables word-crossing access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_param
    import dm_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 64,
    parameter int INIT_SEQ = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int          RAM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] C_MEM_BYTES = 33'(DEPTH) * 33'd4;
    localparam logic [32:0] C_ADDR_SPAN = 33'd1 << ADDR_W;

    dm_state_e         state_q, state_d;
    logic              we_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic [2:0]  w_size;
    logic [32:0] w_last;
    logic        w_oor;
    logic        w_misalign;
    logic        w_err;

    logic              ram_en;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [RAM_AW-1:0] w_word0;
    logic [7:0]        w_be;
    logic [63:0]       w_st;
    logic [31:0]       w_load;

    always_comb begin
        w_size = type_size(req_type);
        w_last = 33'(req_addr) + 33'(w_size) - 33'd1;
        w_oor  = (w_last >= C_MEM_BYTES) || (w_last >= C_ADDR_SPAN);
`ifdef DM_MISALIGN_SPLIT_EN
        w_misalign = 1'b0;
`else
        w_misalign = (((req_type == DM_HALF) || (req_type == DM_HALFU)) && req_addr[0])
                   || ((req_type == DM_WORD) && (req_addr[1:0] != 2'b00));
`endif
        w_err = type_illegal(req_type) || w_oor || w_misalign;
    end

    assign w_word0 = RAM_AW'(addr_q[ADDR_W-1:2]);
    assign w_be    = lane_be(type_q, addr_q[1:0]);
    assign w_st    = store_align(wdata_q, addr_q[1:0]);

`ifdef DM_MISALIGN_SPLIT_EN
    logic        cross_q;
    logic [31:0] lo_q;
    logic        w_cross;
    logic [31:0] w_pair;

    assign w_cross = (4'(req_addr[1:0]) + 4'(w_size)) > 4'd4;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cross_q <= 1'b0;
            lo_q    <= '0;
        end else begin
            if ((state_q == ST_IDLE) && req_valid) begin
                cross_q <= w_cross && !w_err;
            end
            if (state_q == ST_ACC2) begin
                lo_q <= ram_rdata;
            end
        end
    end

    // A crossing load joins the first word (captured during ACC2) with the second.
    always_comb begin
        w_pair = 32'({ram_rdata, lo_q} >> {addr_q[1:0], 3'b000});
        w_load = cross_q ? load_extend(w_pair, type_q, 2'b00)
                         : load_extend(ram_rdata, type_q, addr_q[1:0]);
    end
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{w_be[7:4], w_st[63:32]};
    assign w_load      = load_extend(ram_rdata, type_q, addr_q[1:0]);
`endif

    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = w_be[3:0];
        ram_addr  = w_word0;
        ram_wdata = w_st[31:0];
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_ACC1;
                end
            end
            ST_ACC1: begin
                ram_en = !err_q;
                ram_we = we_q;
`ifdef DM_MISALIGN_SPLIT_EN
                state_d = cross_q ? ST_ACC2 : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef DM_MISALIGN_SPLIT_EN
            ST_ACC2: begin
                ram_en    = 1'b1;
                ram_we    = we_q;
                ram_be    = w_be[7:4];
                ram_addr  = w_word0 + RAM_AW'(1);
                ram_wdata = w_st[63:32];
                state_d   = ST_RESP;
            end
`endif
            ST_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The first RESP cycle lets the synchronous read settle before the response is registered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            type_q      <= DM_WORD;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && req_valid) begin
                we_q    <= req_we;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= w_err;
            end
            if (state_q == ST_RESP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_rdata_q <= (err_q || we_q) ? 32'd0 : w_load;
                end else if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end
    end

    dm_ram #(
        .DEPTH    (DEPTH),
        .AW       (RAM_AW),
        .INIT_SEQ (INIT_SEQ)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_param
// Description : Scoreboard bench for dmem_param; expectations follow the
//               DM_MISALIGN_SPLIT_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_param;
    import dm_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_type;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        int          tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   tag_cnt  = 0;

    dmem_param #(.ADDR_W(8), .DEPTH(64), .INIT_SEQ(1)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s txn%0d: got %08h expected %08h", nm, tag, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted response.
    initial begin : monitor
        int   rise_cyc;
        logic prev_v;
        exp_t e;
        rise_cyc = 0;
        prev_v   = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_v) rise_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected response: got %08h expected none", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata",   e.tag, rsp_rdata, e.rdata);
                    check("err",     e.tag, 32'(rsp_err), 32'(e.err));
                    check("latency", e.tag, 32'(rise_cyc - e.acc), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue_start(input logic we, input logic [2:0] t, input logic [7:0] a,
                               input logic [31:0] wd, input logic [31:0] er, input logic ee,
                               input int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        tag_cnt++;
        if (!req_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_ready txn%0d: got 0 expected 1 within 50 cycles", tag_cnt);
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        exp_q.push_back('{rdata: er, err: ee, lat: lat, acc: cyc, tag: tag_cnt});
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL response timeout txn%0d: got none expected response", tag_cnt);
            exp_q.delete();
        end
    endtask

    task automatic txn(input logic we, input logic [2:0] t, input logic [7:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee, input int lat);
        issue_start(we, t, a, wd, er, ee, lat);
        wait_done();
    endtask

    initial begin : stim
        int guard;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_type  = DM_WORD;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst req_ready", 0, 32'(req_ready), 32'd1);
        check("rst rsp_valid", 0, 32'(rsp_valid), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rst rsp_rdata", 0, rsp_rdata, 32'd0);
        check("rst rsp_err",   0, 32'(rsp_err), 32'd0);

        // initial image and byte store
        txn(1'b0, DM_WORD,  8'h04, 32'h0,        32'h07060504, 1'b0, 2);
        txn(1'b1, DM_BYTE,  8'h09, 32'h123456A5, 32'h00000000, 1'b0, 2);
        txn(1'b0, DM_BYTE,  8'h09, 32'h0,        32'hFFFFFFA5, 1'b0, 2);
        txn(1'b0, DM_BYTEU, 8'h09, 32'h0,        32'h000000A5, 1'b0, 2);
        txn(1'b0, DM_WORD,  8'h08, 32'h0,        32'h0B0AA508, 1'b0, 2);

        // half store and sign/zero extension
        txn(1'b1, DM_HALF,  8'h02, 32'hFFFF8001, 32'h00000000, 1'b0, 2);
        txn(1'b0, DM_HALF,  8'h02, 32'h0,        32'hFFFF8001, 1'b0, 2);
        txn(1'b0, DM_HALFU, 8'h02, 32'h0,        32'h00008001, 1'b0, 2);
        txn(1'b0, DM_WORD,  8'h00, 32'h0,        32'h80010100, 1'b0, 2);

        // misaligned accesses
`ifdef DM_MISALIGN_SPLIT_EN
        txn(1'b0, DM_WORD,  8'h05, 32'h0,        32'h08070605, 1'b0, 3);
        txn(1'b0, DM_HALF,  8'h05, 32'h0,        32'h00000605, 1'b0, 2);
        txn(1'b0, DM_HALF,  8'h03, 32'h0,        32'h00000480, 1'b0, 3);
        txn(1'b1, DM_WORD,  8'h31, 32'hCAFEF00D, 32'h00000000, 1'b0, 3);
        txn(1'b0, DM_WORD,  8'h30, 32'h0,        32'hFEF00D30, 1'b0, 2);
        txn(1'b0, DM_BYTE,  8'h34, 32'h0,        32'hFFFFFFCA, 1'b0, 2);
`else
        txn(1'b0, DM_WORD,  8'h05, 32'h0,        32'h00000000, 1'b1, 2);
        txn(1'b0, DM_HALF,  8'h05, 32'h0,        32'h00000000, 1'b1, 2);
        txn(1'b0, DM_HALF,  8'h03, 32'h0,        32'h00000000, 1'b1, 2);
        txn(1'b1, DM_WORD,  8'h31, 32'hCAFEF00D, 32'h00000000, 1'b1, 2);
        txn(1'b0, DM_WORD,  8'h30, 32'h0,        32'h33323130, 1'b0, 2);
        txn(1'b0, DM_BYTE,  8'h34, 32'h0,        32'h00000034, 1'b0, 2);
`endif

        // top of memory
        txn(1'b0, DM_WORD,  8'hFE, 32'h0,        32'h00000000, 1'b1, 2);
        txn(1'b0, DM_WORD,  8'hFC, 32'h0,        32'hFFFEFDFC, 1'b0, 2);
        txn(1'b0, DM_HALF,  8'hFE, 32'h0,        32'hFFFFFFFE, 1'b0, 2);
        txn(1'b0, DM_BYTE,  8'hFF, 32'h0,        32'hFFFFFFFF, 1'b0, 2);

        // illegal-type store with the consumer stalling
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        issue_start(1'b1, 3'b111, 8'h20, 32'h55555555, 32'h00000000, 1'b1, 2);
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) begin
            @(negedge clk);
            check("stall rsp_valid", tag_cnt, 32'(rsp_valid), 32'd1);
            check("stall req_ready", tag_cnt, 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_done();
        txn(1'b0, DM_WORD,  8'h20, 32'h0,        32'h23222120, 1'b0, 2);

        // reset while the store sits in ACC1
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_type  = DM_WORD;
        req_addr  = 8'h10;
        req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rstn      = 1'b0;
        #1;
        check("midrst rsp_valid", tag_cnt, 32'(rsp_valid), 32'd0);
        check("midrst req_ready", tag_cnt, 32'(req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        txn(1'b0, DM_WORD,  8'h10, 32'h0,        32'h13121110, 1'b0, 2);

        repeat (4) @(negedge clk);
        check("queue drained", tag_cnt, 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
